// File: rtl/str_unpack.sv
// str_unpack: wide-to-narrow stream unpacker.
// Splits each accepted wide word into its valid narrow lanes (lane 0 first),
// flagging dn_last on the final valid lane of a word that carried up_last.
// Optional build macro: STR_UNPACK_ERR_EN adds a sticky err output that is set
// when a word is accepted with up_cnt larger than the lane count.
module str_unpack #(
  parameter int DATA_UP_WIDTH = 8,
  parameter int DATA_DN_WIDTH = 2,
  parameter int CNT_WIDTH     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_UP_WIDTH-1:0] up_data,
  input  logic [CNT_WIDTH-1:0]     up_cnt,
  input  logic                     up_last,
  input  logic                     up_val,
  output logic                     up_rdy,
  input  logic                     dn_rdy,
  output logic [DATA_DN_WIDTH-1:0] dn_data,
  output logic                     dn_last,
  output logic                     dn_val
`ifdef STR_UNPACK_ERR_EN
  ,
  output logic                     err
`endif
);

  localparam int NB = DATA_UP_WIDTH / DATA_DN_WIDTH;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_WIDTH-1:0] NB_C  = CNT_WIDTH'(NB);
  localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                   state;
  state_t                   nxt_state;
  logic [DATA_UP_WIDTH-1:0] hold_data;
  logic [DATA_UP_WIDTH-1:0] nxt_data;
  logic [CNT_WIDTH-1:0]     hold_cnt;
  logic [CNT_WIDTH-1:0]     nxt_cnt;
  logic                     hold_last;
  logic                     nxt_last;
  logic [IW-1:0]            idx;
  logic [IW-1:0]            nxt_idx;
  logic [DATA_DN_WIDTH-1:0] nxt_dn_data;
  logic                     nxt_dn_last;
  logic                     nxt_dn_val;
  logic [CNT_WIDTH-1:0]     eff_cnt;
  logic                     last_lane;
  logic                     do_load;

  // Select narrow lane i out of a wide word.
  function automatic logic [DATA_DN_WIDTH-1:0] lane_of(
    input logic [DATA_UP_WIDTH-1:0] d,
    input logic [IW-1:0]            i
  );
    return d[i*DATA_DN_WIDTH +: DATA_DN_WIDTH];
  endfunction

  // Effective lane count of the incoming word: 0 means full, oversize clamps to full.
  always_comb begin
    if ((up_cnt == {CNT_WIDTH{1'b0}}) || (up_cnt > NB_C)) begin
      eff_cnt = NB_C;
    end else begin
      eff_cnt = up_cnt;
    end
  end

  assign last_lane = (CNT_WIDTH'(idx) == (hold_cnt - ONE_C));

  // Ready while empty, or when the final lane of the held word is leaving; blocked in reset.
  assign up_rdy = rst & ((state == EMPTY) | (dn_rdy & (state == SHIFT) & last_lane));

  // Next-state and next-output logic for the holding register.
  always_comb begin
    nxt_state   = state;
    nxt_data    = hold_data;
    nxt_cnt     = hold_cnt;
    nxt_last    = hold_last;
    nxt_idx     = idx;
    nxt_dn_data = dn_data;
    nxt_dn_last = dn_last;
    nxt_dn_val  = dn_val;
    do_load     = 1'b0;
    case (state)
      EMPTY: begin
        if (up_val) begin
          do_load = 1'b1;
        end else begin
          nxt_dn_val  = 1'b0;
          nxt_dn_last = 1'b0;
        end
      end
      SHIFT: begin
        if (dn_rdy) begin
          if (last_lane) begin
            if (up_val) begin
              do_load = 1'b1;
            end else begin
              nxt_state   = EMPTY;
              nxt_dn_val  = 1'b0;
              nxt_dn_last = 1'b0;
            end
          end else begin
            nxt_idx     = idx + IW'(1);
            nxt_dn_data = lane_of(hold_data, nxt_idx);
            nxt_dn_last = hold_last & (CNT_WIDTH'(nxt_idx) == (hold_cnt - ONE_C));
          end
        end else begin
          nxt_state = state;
        end
      end
      default: begin
        nxt_state   = EMPTY;
        nxt_dn_val  = 1'b0;
        nxt_dn_last = 1'b0;
      end
    endcase
    if (do_load) begin
      nxt_state   = SHIFT;
      nxt_data    = up_data;
      nxt_cnt     = eff_cnt;
      nxt_last    = up_last;
      nxt_idx     = {IW{1'b0}};
      nxt_dn_data = lane_of(up_data, {IW{1'b0}});
      nxt_dn_last = up_last & (eff_cnt == ONE_C);
      nxt_dn_val  = 1'b1;
    end else begin
      nxt_idx = nxt_idx;
    end
  end

  // State, holding register and registered downstream outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      hold_data <= {DATA_UP_WIDTH{1'b0}};
      hold_cnt  <= NB_C;
      hold_last <= 1'b0;
      idx       <= {IW{1'b0}};
      dn_data   <= {DATA_DN_WIDTH{1'b0}};
      dn_last   <= 1'b0;
      dn_val    <= 1'b0;
    end else begin
      state     <= nxt_state;
      hold_data <= nxt_data;
      hold_cnt  <= nxt_cnt;
      hold_last <= nxt_last;
      idx       <= nxt_idx;
      dn_data   <= nxt_dn_data;
      dn_last   <= nxt_dn_last;
      dn_val    <= nxt_dn_val;
    end
  end

`ifdef STR_UNPACK_ERR_EN
  // Sticky flag: an accepted word claimed more lanes than the word holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (up_val && up_rdy && (up_cnt > NB_C)) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end
`endif

endmodule

// File: tb/tb_str_unpack.sv
// Self-checking bench for str_unpack (DATA_UP_WIDTH=8, DATA_DN_WIDTH=2, NB=4).
module tb_str_unpack;

  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] up_data = 8'h00;
  logic [2:0] up_cnt = 3'd0;
  logic       up_last = 1'b0;
  logic       up_val = 1'b0;
  logic       up_rdy;
  logic       dn_rdy = 1'b0;
  logic [1:0] dn_data;
  logic       dn_last;
  logic       dn_val;
`ifdef STR_UNPACK_ERR_EN
  logic       err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  logic [2:0] obs[$];
  int         obs_cyc[$];
  logic [2:0] exp_q[$];

  str_unpack #(.DATA_UP_WIDTH(8), .DATA_DN_WIDTH(2), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .up_data(up_data), .up_cnt(up_cnt), .up_last(up_last), .up_val(up_val), .up_rdy(up_rdy),
    .dn_rdy(dn_rdy), .dn_data(dn_data), .dn_last(dn_last), .dn_val(dn_val)
`ifdef STR_UNPACK_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  // Record every downstream transfer with its cycle number.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (rst && dn_val && dn_rdy) begin
      obs.push_back({dn_last, dn_data});
      obs_cyc.push_back(cycle);
    end
  end

  // Reference: an accepted word yields its valid lanes in order, last on the final one.
  task automatic model_push(input logic [7:0] d, input int c, input logic l);
    int n;
    n = (c == 0 || c > NB) ? NB : c;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({l && (k == n - 1), 2'((d >> (2 * k)) & 8'h03)});
    end
  endtask

  task automatic clear_q();
    obs.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one word and hold it until accepted; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] d, input logic [2:0] c, input logic l);
    bit acc;
    acc = 1'b0;
    up_data = d; up_cnt = c; up_last = l; up_val = 1'b1;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (up_rdy) begin
        model_push(d, int'(c), l);
        acc = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    up_val = 1'b0;
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_timeout: word %h not accepted, required acceptance within 200 cycles", d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    dn_rdy = 1'b1;
    idle(3);
    n_checks++;
    if (dn_val !== 1'b0 || dn_last !== 1'b0 || dn_data !== 2'd0 || up_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: val=%b last=%b data=%0d up_rdy=%b, required 0 0 0 0",
               dn_val, dn_last, dn_data, up_rdy);
    end
`ifdef STR_UNPACK_ERR_EN
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: err=%b required 0", err);
    end
`endif
    rst = 1'b1;
    #1;
    n_checks++;
    if (up_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_rdy: up_rdy=%b required 1", up_rdy);
    end
    @(negedge clk);
  endtask

  task automatic test_full_word();
    logic [1:0] expv[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    clear_q();
    dn_rdy = 1'b1;
    send(8'hE4, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dn_val !== 1'b1 || dn_data !== expv[i] || dn_last !== 1'b0 || up_rdy !== (i == 3)) begin
        n_fail++;
        $display("FAIL full_beat%0d: val=%b data=%0d last=%b up_rdy=%b, required 1 %0d 0 %b",
                 i, dn_val, dn_data, dn_last, up_rdy, expv[i], (i == 3));
      end
      @(negedge clk);
    end
    n_checks++;
    if (dn_val !== 1'b0 || up_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_after: val=%b up_rdy=%b, required 0 1", dn_val, up_rdy);
    end
  endtask

  task automatic test_partial_last();
    clear_q();
    dn_rdy = 1'b1;
    send(8'hB1, 3'd2, 1'b1);
    idle(6);
    n_checks++;
    if (obs.size() != 2) begin
      n_fail++;
      $display("FAIL partial_count: got %0d beats, required 2", obs.size());
    end
    for (int i = 0; i < obs.size() && i < 2; i++) begin
      n_checks++;
      if (obs[i] !== ((i == 0) ? 3'b0_01 : 3'b1_00)) begin
        n_fail++;
        $display("FAIL partial_beat%0d: {last,data}=%b required %b", i, obs[i],
                 (i == 0) ? 3'b0_01 : 3'b1_00);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    clear_q();
    dn_rdy = 1'b1;
    up_data = 8'h1B; up_cnt = 3'd0; up_last = 1'b0; up_val = 1'b1;
    #1;
    if (up_rdy) model_push(8'h1B, 0, 1'b0);
    @(negedge clk);
    up_data = 8'hE4;
    acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (up_rdy) begin
        model_push(8'hE4, 0, 1'b0);
        acc = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    up_val = 1'b0;
    idle(8);
    n_checks++;
    if (!acc || obs.size() != 8 || exp_q.size() != 8) begin
      n_fail++;
      $display("FAIL b2b_count: accepted=%b beats=%0d model=%0d, required 1 8 8", acc, obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got %b required %b", i, obs[i], exp_q[i]);
      end
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      n_checks++;
      if (obs_cyc[i] != obs_cyc[i-1] + 1) begin
        n_fail++;
        $display("FAIL b2b_bubble%0d: gap of %0d cycles, required 1", i, obs_cyc[i] - obs_cyc[i-1]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [6:0] pat = 7'b1010101;
    logic [1:0] prev;
    clear_q();
    dn_rdy = 1'b1;
    send(8'h1B, 3'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      dn_rdy = pat[6 - i];
      prev = dn_data;
      @(negedge clk);
      if (!pat[6 - i]) begin
        n_checks++;
        if (dn_val !== 1'b1 || dn_data !== prev) begin
          n_fail++;
          $display("FAIL bp_stall%0d: val=%b data=%0d, required 1 %0d", i, dn_val, dn_data, prev);
        end
      end
    end
    dn_rdy = 1'b1;
    idle(4);
    n_checks++;
    if (obs.size() != 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d transfers, required 4", obs.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got %b required %b", i, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    clear_q();
    dn_rdy = 1'b1;
    send(8'hE4, 3'd0, 1'b0);
    idle(2);
    n_checks++;
    if (dn_data !== 2'd2 || dn_val !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: data=%0d val=%b, required 2 1", dn_data, dn_val);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (dn_val !== 1'b0 || dn_data !== 2'd0 || dn_last !== 1'b0 || up_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_now: val=%b data=%0d last=%b up_rdy=%b, required 0 0 0 0",
               dn_val, dn_data, dn_last, up_rdy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_q();
    send(8'h1B, 3'd0, 1'b0);
    idle(6);
    n_checks++;
    if (obs.size() != 4) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d beats, required 4", obs.size());
    end
    for (int i = 0; i < obs.size() && i < 4; i++) begin
      n_checks++;
      if (obs[i] !== {1'b0, 2'(3 - i)}) begin
        n_fail++;
        $display("FAIL midrst_beat%0d: got %b required %b", i, obs[i], {1'b0, 2'(3 - i)});
      end
    end
  endtask

  task automatic test_overflow();
    clear_q();
    dn_rdy = 1'b1;
`ifdef STR_UNPACK_ERR_EN
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_err_before: err=%b required 0", err);
    end
`endif
    send(8'hE4, 3'd5, 1'b0);
`ifdef STR_UNPACK_ERR_EN
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_err_set: err=%b required 1", err);
    end
`endif
    idle(10);
    n_checks++;
    if (obs.size() != 4) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d beats, required 4", obs.size());
    end
    for (int i = 0; i < obs.size() && i < 4; i++) begin
      n_checks++;
      if (obs[i] !== {1'b0, 2'(i)}) begin
        n_fail++;
        $display("FAIL ovf_beat%0d: got %b required %b", i, obs[i], {1'b0, 2'(i)});
      end
    end
`ifdef STR_UNPACK_ERR_EN
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_err_sticky: err=%b required 1", err);
    end
`endif
  endtask

  task automatic test_random();
    bit pending;
    int guard;
    logic [7:0] d;
    logic [2:0] c;
    logic       l;
    clear_q();
    pending = 1'b0;
    d = 8'h00; c = 3'd0; l = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      dn_rdy = ($urandom_range(0, 3) != 0);
      if (!pending) begin
        up_val = 1'b0;
        if ($urandom_range(0, 2) != 0) begin
          d = 8'($urandom);
          c = 3'($urandom_range(0, 7));
          l = 1'($urandom);
          up_data = d; up_cnt = c; up_last = l; up_val = 1'b1;
          pending = 1'b1;
        end
      end
      #1;
      if (pending && up_rdy) begin
        model_push(d, int'(c), l);
        pending = 1'b0;
      end
      @(negedge clk);
    end
    dn_rdy = 1'b1;
    guard = 0;
    while (pending && guard < 50) begin
      #1;
      if (up_rdy) begin
        model_push(d, int'(c), l);
        pending = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    up_val = 1'b0;
    idle(20);
    n_checks++;
    if (pending || obs.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: stuck=%b beats=%0d, required 0 and %0d", pending, obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_beat%0d: got %b required %b", i, obs[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_word();
    test_partial_last();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/str_unpack.md
Name: str_unpack

Overview:
- Counterpart to the stream deserializer in the gearbox. It takes a wide stream word that carries a valid-lane count and breaks it into narrow words.
- Only the valid lanes are emitted, lowest lane first. dn_last is placed on the final valid lane of an up word that had up_last set.
- Partially filled wide words, for example those flushed early by a last, are therefore unpacked without emitting garbage lanes.
- Sits between wide internal buses and narrow consumers in the coprocessor stream fabric.

Parameters:
- DATA_UP_WIDTH, 8: wide input word width. Must be an integer multiple of DATA_DN_WIDTH.
- DATA_DN_WIDTH, 2: narrow output word width.
- CNT_WIDTH, 3: width of up_cnt. Must be at least clog2(NB)+1, where NB = DATA_UP_WIDTH/DATA_DN_WIDTH (localparam).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = in reset).
- up_data  in  DATA_UP_WIDTH  wide word; lane k = up_data[k*DATA_DN_WIDTH +: DATA_DN_WIDTH].
- up_cnt  in  CNT_WIDTH  number of valid lanes, starting at lane 0. 0 means NB (full word).
- up_last  in  1  end of packet.
- up_val  in  1  up word valid.
- up_rdy  out  1  block accepts the up word this cycle.
- dn_data  out  DATA_DN_WIDTH  narrow output word.
- dn_last  out  1  final narrow word of the packet.
- dn_val  out  1  narrow word valid.
- dn_rdy  in  1  downstream accepts.
- err  out  1  present only with STR_UNPACK_ERR_EN; sticky count-overflow flag.

Behaviour:
- Handshake: valid/ready on both sides.
  - A transfer occurs when val & rdy on a rising edge.
  - dn_val, dn_data and dn_last are registered and have no combinational path from dn_rdy.
  - Once dn_val is high, dn_data and dn_last hold stable until the transfer.
- Storage is one holding register: data, effective count N, last flag, lane index idx (0..NB-1).
- State machine:
  - EMPTY: no word held.
  - SHIFT: a word is held and dn_val=1.
- up_rdy = (state==EMPTY) | (dn_rdy & idx==N-1). up_rdy is combinational from state and dn_rdy only, never from up_val.
- Accept (up_val & up_rdy):
  - Load up_data; N = (up_cnt==0) ? NB : up_cnt; idx=0; go to or stay in SHIFT.
  - dn_data takes lane 0 on the next cycle, so latency is 1 cycle.
- In SHIFT, on each dn transfer with idx<N-1: idx increments and dn_data takes lane idx+1.
- On the dn transfer with idx==N-1:
  - If up_val is high, load the next word; this gives back-to-back operation with no bubble.
  - Otherwise go to EMPTY and set dn_val=0.
- dn_last = held last & (idx==N-1). It is 0 on every other lane.
- Sustained throughput is one narrow word per cycle while dn_rdy=1. An up word with N lanes occupies exactly N output cycles.
- When dn_rdy=0, all state holds. up_rdy=0 unless state is EMPTY.
- up_cnt > NB: N is clamped to NB.
- Reset asserted, including mid-word:
  - Takes effect immediately and asynchronously. The held word is discarded.
  - state=EMPTY, idx=0, dn_val=0, dn_last=0, dn_data=0, up_rdy=0.
  - After release, up_rdy=1 (EMPTY), and the next word starts at lane 0.
- NB==1 degenerates to a one-deep registered pass-through with identical handshake rules.

Optional Feature:
- Macro STR_UNPACK_ERR_EN.
- Defined:
  - err port exists; reset value 0.
  - err is set on any accepted up word with up_cnt > NB and stays high until reset.
  - Clamping still applies.
- Undefined: no err port and no error logic. Clamping is silent.

Test Plan (all scenarios use DATA_UP_WIDTH=8, DATA_DN_WIDTH=2, NB=4):
- Full word: up_data=8'hE4, up_cnt=0, up_last=0, dn_rdy=1.
  - dn_data = 0,1,2,3 on 4 consecutive cycles, first beat 1 cycle after accept.
  - dn_last=0 throughout. up_rdy=1 only in EMPTY and on the lane-3 cycle.
- Partial last: up_data=8'hB1, up_cnt=2, up_last=1.
  - dn_data = 1 then 0, with dn_last=1 on the second beat only.
  - Lanes 2 and 3 (values 3, 2) are never emitted.
- Back-to-back: two full words 8'h1B and 8'hE4, with up_val and dn_rdy held at 1.
  - 8 consecutive dn beats 3,2,1,0,0,1,2,3 with no bubble.
- Backpressure: full word 8'h1B with dn_rdy pattern 1,0,1,0,1,0,1.
  - dn_val stays high and dn_data holds during stalls.
  - Exactly 4 transfers, values 3,2,1,0, with no lane lost or duplicated.
- Reset mid-word: assert rst=0 while idx=2 of word 8'hE4.
  - dn_val drops in the same cycle.
  - After release, word 8'h1B emits 3,2,1,0 starting at lane 0.
- Overflow: up_cnt=5, up_data=8'hE4.
  - Emits exactly 4 beats (0,1,2,3).
  - With STR_UNPACK_ERR_EN, err=1 after accept and still 1 after 10 idle cycles.
